varint_encoder: RTL and testbench
=================================

Name: varint_encoder

Overview:
- Downstream stage of the zigzag encoder.
- Takes one 64-bit (zigzag-encoded or plain unsigned) field value per transaction and serializes it as a protobuf base-128 varint.
- Output is a byte stream, one byte per cycle, with valid/ready handshakes on both sides.
- Feeds the field serializer / output byte FIFO.

Parameters:
- MAX_BYTES, 10, maximum varint length in bytes; must be 10 to cover 64-bit values. Sizes the byte counter.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  in_val/in_is_32 hold a value to encode
- in_ready  output  1  encoder accepts a value this cycle
- in_val  input  64  value to encode (zigzag output or raw varint field)
- in_is_32  input  1  encode only in_val[31:0]; upper 32 bits are treated as zero
- out_valid  output  1  out_byte is valid
- out_ready  input  1  downstream accepts out_byte this cycle
- out_byte  output  8  varint byte; bit7 = continuation, bits6:0 = payload
- out_last  output  1  out_byte is the final byte of the current varint

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, out_last=0, out_byte=8'h00, internal shift register and counter cleared. Any in-flight varint is discarded; no partial bytes appear after reset deasserts.
- States: IDLE, EMIT.
- IDLE: in_ready=1, out_valid=0.
  - On in_valid && in_ready: latch value (masked to [31:0] if in_is_32) into a 64-bit shift register.
  - Compute length L = max(1, ceil(bitlen/7)), where bitlen is the index of the highest set bit + 1. L range: 1..10 for 64-bit, 1..5 when in_is_32.
  - Load the remaining-byte counter with L and go to EMIT.
- Latency: value accepted in cycle N -> first byte presented (out_valid=1) in cycle N+1.
- EMIT: out_valid=1.
  - out_byte = {counter>1, shreg[6:0]}; out_last = (counter==1).
  - On out_ready: shreg >>= 7, counter -= 1. Then:
    - if out_last, go to IDLE;
    - otherwise stay in EMIT and present the next byte in the next cycle.
  - While out_ready=0: out_byte, out_last and out_valid hold stable (no change, no drop).
- Back-to-back: in_ready = (state==IDLE) || (out_valid && out_last && out_ready).
  - A new value accepted in the same cycle the last byte is consumed goes straight to EMIT.
  - Sustained throughput: L output cycles per value, no bubble.
- in_val and in_is_32 are sampled only on an accept cycle; changes at other times are ignored.
- Value 0 encodes as the single byte 8'h00 with out_last=1.
- The 10th byte of a 64-bit value carries only bit 63 (payload 7'h01 or 7'h00 never emitted as non-last). Its continuation bit is always 0.
- Bytes are emitted little-endian in 7-bit groups (least significant group first), per the protobuf wire format.
- No arithmetic overflow: the counter is 4 bits (0..10) and never wraps.

Optional Feature:
- Macro: VARINT_LEN_EN.
- Defined: adds output port out_len (4 bits) = L, the total byte count of the varint currently being emitted.
  - Valid whenever out_valid=1, constant across all bytes of one varint.
  - Reset value 0, and 0 while IDLE.
  - Used by the length-delimited field stage to precompute sizes.
- Not defined: port and length register absent; all other behaviour identical.

Test Plan:
- in_val=0, is_32=0, out_ready=1 -> single byte 8'h00, out_last=1, first byte in cycle after accept, in_ready high again the same cycle.
- in_val=300 -> bytes 8'hAC, 8'h02; out_last on second byte only (with VARINT_LEN_EN: out_len=2 on both).
- in_val=64'hFFFF_FFFF_FFFF_FFFF, is_32=0 -> nine bytes 8'hFF then 8'h01 (10 total); with is_32=1 -> 8'hFF x4 then 8'h0F.
- in_val=150, out_ready held low 3 cycles after first byte -> 8'h96 held stable with out_valid=1, then 8'h96, 8'h01 once out_ready rises; no byte lost or duplicated.
- Back-to-back in_valid with values 1, 128, 2 and out_ready=1 -> stream 01 | 80 01 | 02 with no idle cycle between varints.
- rst asserted mid-way through emitting 64'hFFFF_FFFF_FFFF_FFFF (after 4 bytes) -> out_valid drops immediately, in_ready=1; a subsequent in_val=5 yields exactly 8'h05 with out_last=1.

Source files
------------

// File: rtl/varint_encoder.sv
// Serializes one 64-bit field value (or its low 32 bits) into a protobuf base-128 varint byte stream.
// Latency: value accepted in cycle N, first byte valid in cycle N+1; one byte per cycle afterwards.
// Backpressure: out_ready low freezes the current byte; in_ready only in IDLE or on the last byte's handshake.
// Optional out_len port (total byte count of the current varint) under `define VARINT_LEN_EN.
module varint_encoder #(
    parameter int MAX_BYTES = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [63:0]                    in_val,
    input  logic                           in_is_32,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [7:0]                     out_byte,
    output logic                           out_last
`ifdef VARINT_LEN_EN
    ,
    output logic [$clog2(MAX_BYTES+1)-1:0] out_len
`endif
);

    localparam int CW = $clog2(MAX_BYTES + 1);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t          state;
    logic [63:0]     shreg;
    logic [CW-1:0]   cnt;
    logic [63:0]     val_masked;
    logic [6:0]      bitlen;
    logic [CW-1:0]   len_calc;
    logic            accept;
    logic            consume;

    // Varint length from the position of the highest set bit; zero still needs one byte.
    always_comb begin
        val_masked = in_is_32 ? {32'h0, in_val[31:0]} : in_val;
        bitlen     = 7'd0;
        for (int i = 0; i < 64; i++) begin
            if (val_masked[i]) begin
                bitlen = 7'(i + 1);
            end
        end
        len_calc = (bitlen == 7'd0) ? CW'(1) : CW'((bitlen + 7'd6) / 7'd7);
    end

    assign consume  = out_valid && out_ready;
    assign in_ready = (state == IDLE) || (consume && out_last);
    assign accept   = in_valid && in_ready;

`ifdef VARINT_LEN_EN
    logic [CW-1:0] len_q;
    assign out_len = len_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_byte  <= 8'h00;
            out_last  <= 1'b0;
`ifdef VARINT_LEN_EN
            len_q     <= '0;
`endif
        end else if (accept) begin
            // Covers both the IDLE accept and the back-to-back accept on a last-byte handshake.
            state     <= EMIT;
            shreg     <= val_masked;
            cnt       <= len_calc;
            out_valid <= 1'b1;
            out_byte  <= {len_calc > CW'(1), val_masked[6:0]};
            out_last  <= (len_calc == CW'(1));
`ifdef VARINT_LEN_EN
            len_q     <= len_calc;
`endif
        end else if (state == EMIT && out_ready) begin
            shreg <= shreg >> 7;
            cnt   <= cnt - CW'(1);
            if (out_last) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_byte  <= 8'h00;
                out_last  <= 1'b0;
`ifdef VARINT_LEN_EN
                len_q     <= '0;
`endif
            end else begin
                // Pre-load the byte that follows the one being consumed now.
                out_byte <= {cnt > CW'(2), shreg[13:7]};
                out_last <= (cnt == CW'(2));
            end
        end
    end

endmodule

// File: tb/tb_varint_encoder.sv
// Self-checking bench for varint_encoder: fixed vectors, hand-written corner sequences, randomized scoreboard run.
module tb_varint_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_val;
    logic        in_is_32;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
`ifdef VARINT_LEN_EN
    logic [3:0]  out_len;
`endif

    int checks = 0;
    int errors = 0;

    varint_encoder #(.MAX_BYTES(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_val    (in_val),
        .in_is_32  (in_is_32),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last)
`ifdef VARINT_LEN_EN
        ,
        .out_len   (out_len)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fixed vectors: bytes packed least-significant first, byte k at bits [8k+7:8k].
    typedef struct {
        logic [63:0] val;
        logic        is32;
        int          n;
        logic [79:0] bytes;
    } vec_t;

    vec_t vecs[11];

    task automatic set_vec(input int idx, input logic [63:0] v, input logic i32, input int n,
                           input logic [79:0] b);
        vecs[idx].val   = v;
        vecs[idx].is32  = i32;
        vecs[idx].n     = n;
        vecs[idx].bytes = b;
    endtask

    // Reference model: expected entries {len[3:0], last, byte[7:0]}.
    logic [12:0] exp_q[$];

    task automatic push_exp(input logic [63:0] v, input logic i32);
        logic [63:0] x;
        logic [7:0]  bs[$];
        int          n;
        x = i32 ? (v % 64'h1_0000_0000) : v;
        do begin
            logic [63:0] grp;
            grp = x % 64'd128;
            x   = x / 64'd128;
            bs.push_back({(x != 64'd0), grp[6:0]});
        end while (x != 64'd0);
        n = bs.size();
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({4'(n), (k == n - 1), bs[k]});
        end
    endtask

    task automatic cyc(input logic iv, input logic [63:0] v, input logic i32, input logic ordy);
        logic exp_ir;
        in_valid  = iv;
        in_val    = v;
        in_is_32  = i32;
        out_ready = ordy;
        #1;
        exp_ir = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
        chk("rnd in_ready", in_ready, exp_ir);
        chk("rnd out_valid", out_valid, exp_q.size() != 0);
        if (out_valid && exp_q.size() != 0) begin
            chk("rnd out_byte", out_byte, exp_q[0][7:0]);
            chk("rnd out_last", out_last, exp_q[0][8]);
`ifdef VARINT_LEN_EN
            chk("rnd out_len", out_len, exp_q[0][12:9]);
`endif
            if (ordy) void'(exp_q.pop_front());
        end
        if (iv && exp_ir) push_exp(v, i32);
        tick();
    endtask

    initial begin
        int n;
        logic [79:0] bv;
        logic [63:0] rv;
        int budget;

        set_vec(0,  64'd0,                   1'b0, 1,  80'h00);
        set_vec(1,  64'd300,                 1'b0, 2,  80'h02AC);
        set_vec(2,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 10, 80'h01FF_FFFF_FFFF_FFFF_FFFF);
        set_vec(3,  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5,  80'h0F_FFFF_FFFF);
        set_vec(4,  64'd150,                 1'b0, 2,  80'h0196);
        set_vec(5,  64'd127,                 1'b0, 1,  80'h7F);
        set_vec(6,  64'd128,                 1'b0, 2,  80'h0180);
        set_vec(7,  64'h8000_0000_0000_0000, 1'b0, 10, 80'h0180_8080_8080_8080_8080);
        set_vec(8,  64'hFFFF_FFFF_0000_0080, 1'b1, 2,  80'h0180);
        set_vec(9,  64'd16383,               1'b0, 2,  80'h7FFF);
        set_vec(10, 64'd16384,               1'b0, 3,  80'h01_8080);

        rst = 1'b1; in_valid = 1'b0; in_val = '0; in_is_32 = 1'b0; out_ready = 1'b0;
        #2;
        chk("reset in_ready", in_ready, 1'b1);
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset out_last", out_last, 1'b0);
        chk("reset out_byte", out_byte, 8'h00);
`ifdef VARINT_LEN_EN
        chk("reset out_len", out_len, 4'd0);
`endif
        tick(); tick();
        rst = 1'b0;
        tick();

        // Table-driven vectors with out_ready held high
        for (int i = 0; i < 11; i++) begin
            n  = vecs[i].n;
            bv = vecs[i].bytes;
            in_val = vecs[i].val; in_is_32 = vecs[i].is32; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            chk("vec idle in_ready", in_ready, 1'b1);
            chk("vec idle out_valid", out_valid, 1'b0);
            tick();
            in_valid = 1'b0; in_val = '1; in_is_32 = ~vecs[i].is32;
            for (int k = 0; k < n; k++) begin
                #1;
                chk("vec out_valid", out_valid, 1'b1);
                chk("vec out_byte", out_byte, bv[8*k +: 8]);
                chk("vec out_last", out_last, (k == n - 1));
                if (k == n - 1) chk("vec last in_ready", in_ready, 1'b1);
`ifdef VARINT_LEN_EN
                chk("vec out_len", out_len, 4'(n));
`endif
                tick();
            end
            #1;
            chk("vec done out_valid", out_valid, 1'b0);
            tick();
        end

        // Back-to-back 1, 128, 2: stream 01 | 80 01 | 02 with no bubble
        in_valid = 1'b1; in_val = 64'd1; in_is_32 = 1'b0; out_ready = 1'b1; #1;
        chk("b2b accept0", in_ready, 1'b1);
        tick();
        in_val = 64'd128; #1;
        chk("b2b byte0", {out_valid, out_last, out_byte}, {2'b11, 8'h01});
        chk("b2b ready0", in_ready, 1'b1);
        tick();
        in_val = 64'd2; #1;
        chk("b2b byte1", {out_valid, out_last, out_byte}, {2'b10, 8'h80});
        chk("b2b ready1", in_ready, 1'b0);
        tick();
        #1;
        chk("b2b byte2", {out_valid, out_last, out_byte}, {2'b11, 8'h01});
        chk("b2b ready2", in_ready, 1'b1);
        tick();
        in_valid = 1'b0; #1;
        chk("b2b byte3", {out_valid, out_last, out_byte}, {2'b11, 8'h02});
        tick();
        #1;
        chk("b2b idle", out_valid, 1'b0);
        tick();

        // Stall 150 for 3 cycles on the first byte
        in_valid = 1'b1; in_val = 64'd150; tick();
        in_valid = 1'b0; in_val = '0; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall hold", {out_valid, out_last, out_byte}, {2'b10, 8'h96});
            chk("stall in_ready", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1; #1;
        chk("stall byte0", {out_valid, out_last, out_byte}, {2'b10, 8'h96});
        tick(); #1;
        chk("stall byte1", {out_valid, out_last, out_byte}, {2'b11, 8'h01});
        tick(); #1;
        chk("stall idle", out_valid, 1'b0);
        tick();

        // Reset after 4 bytes of all-ones
        in_valid = 1'b1; in_val = 64'hFFFF_FFFF_FFFF_FFFF; tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rst pre byte", {out_valid, out_byte}, {1'b1, 8'hFF});
            tick();
        end
        rst = 1'b1; #1;
        chk("rst mid out_valid", out_valid, 1'b0);
        chk("rst mid in_ready", in_ready, 1'b1);
        chk("rst mid out_byte", {out_last, out_byte}, 9'h000);
        tick();
        rst = 1'b0; #1;
        chk("rst after out_valid", out_valid, 1'b0);
        tick();
        in_valid = 1'b1; in_val = 64'd5; tick();
        in_valid = 1'b0; #1;
        chk("rst then 5", {out_valid, out_last, out_byte}, {2'b11, 8'h05});
        tick(); #1;
        chk("rst then idle", out_valid, 1'b0);
        tick();

        // Randomized run against the model
        exp_q.delete();
        for (int c = 0; c < 600; c++) begin
            rv = {$urandom, $urandom} >> $urandom_range(0, 63);
            cyc(($urandom_range(0, 2) != 0), rv, ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) != 0));
        end
        budget = 0;
        while ((exp_q.size() != 0 || out_valid) && budget < 200) begin
            cyc(1'b0, '0, 1'b0, 1'b1);
            budget++;
        end
        chk("drain model empty", exp_q.size(), 0);
        chk("drain out_valid", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
